// File: rtl/hex_line_formatter.sv
// hex_line_formatter
// Converts a captured 128-bit word into 32 ASCII hex characters, one nibble
// per cycle, into shadow registers. Both LCD rows are then loaded in a single
// commit edge, so line1/line2 never show a half-converted word.
//
// Optional build macro HEX_LOWERCASE_EN selects lowercase 'a'-'f' for nibble
// values 10-15; without it the digits are uppercase 'A'-'F'.
//
// Handshake: a word is accepted on a rising edge where in_valid and in_ready
// are both 1. in_ready is high only in IDLE. A source that raises in_valid
// while the block is busy must hold in_data stable until in_ready returns.
// Words offered while busy are neither captured nor cause any side effect.

module hex_line_formatter #(
    parameter logic [7:0] PAD_CHAR = 8'h20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic [0:127] line1,
    output logic [0:127] line2,
    output logic         busy,
    output logic         done
);

`ifdef HEX_LOWERCASE_EN
    localparam logic [7:0] ALPHA_BASE = 8'h61;
`else
    localparam logic [7:0] ALPHA_BASE = 8'h41;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;

    logic [0:127] word;
    logic [4:0]   count;
    logic [7:0]   shadow [0:31];
    logic [3:0]   nibble;
    logic [7:0]   ascii;
    logic         accept;

    assign accept = in_valid && in_ready;

    // Select nibble k = count from the captured word (bit 0 is the MSB).
    always_comb begin
        nibble = word[{count, 2'b00} +: 4];
    end

    // Map one nibble value to its ASCII hex character.
    always_comb begin
        ascii = 8'h00;
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = ALPHA_BASE + ({4'h0, nibble} - 8'd10);
        end
    end

    // Next-state and status outputs; IDLE accepts, CONV walks 32 nibbles,
    // COMMIT publishes the shadows.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (count == 5'd31) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset wins over a simultaneous handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the accepted word and advance the nibble counter during CONV;
    // the counter wraps from 31 back to 0 on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            word  <= '0;
            count <= 5'd0;
        end else if (accept) begin
            word  <= in_data;
            count <= 5'd0;
        end else if (state == CONV) begin
            count <= count + 5'd1;
        end
    end

    // Write the converted character into shadow slot k (0-15 row 1, 16-31 row 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                shadow[i] <= PAD_CHAR;
            end
        end else if (state == CONV) begin
            shadow[count] <= ascii;
        end
    end

    // Publish both rows together in COMMIT and pulse done for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            line1 <= {16{PAD_CHAR}};
            line2 <= {16{PAD_CHAR}};
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == COMMIT) begin
                for (int i = 0; i < 16; i++) begin
                    line1[8*i +: 8] <= shadow[i];
                    line2[8*i +: 8] <= shadow[i+16];
                end
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_line_formatter.sv
// Self-checking bench for hex_line_formatter: directed scenarios plus random
// words, with expected rows built from the hex digits of each word.

module tb_hex_line_formatter;

    localparam logic [7:0]   PAD      = 8'h20;
    localparam logic [127:0] PAD_LINE = {16{PAD}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_data;
    logic [0:127] line1;
    logic [0:127] line2;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_q[$];
    logic [127:0] cur1;
    logic [127:0] cur2;

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    hex_line_formatter #(.PAD_CHAR(PAD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .line1    (line1),
        .line2    (line2),
        .busy     (busy),
        .done     (done)
    );

    // Reference model: ASCII for one hex digit.
    function automatic logic [7:0] hex_char(input logic [3:0] d);
        logic [7:0] v;
        v = {4'h0, d};
        if (v < 8'd10) return 8'h30 + v;
`ifdef HEX_LOWERCASE_EN
        return 8'h61 + (v - 8'd10);
`else
        return 8'h41 + (v - 8'd10);
`endif
    endfunction

    // Reference model: row 0 is hex digits 0-15 of the word, row 1 digits 16-31,
    // most significant digit first.
    function automatic logic [127:0] line_of(input logic [127:0] w, input int row);
        logic [127:0] r;
        logic [3:0]   d;
        int           n;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            n = row * 16 + k;
            d = 4'((w >> (4 * (31 - n))) & 128'hF);
            r = (r << 8) | {120'h0, hex_char(d)};
        end
        return r;
    endfunction

    task automatic check_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver + checker for one word. Caller has already set in_valid=1 and
    // in_data=w. Optionally keeps in_valid high with next_w during busy.
    task automatic run_word(input logic [127:0] w, input bit hold_next, input logic [127:0] next_w);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check_b("ready_before_hs", in_ready, 1'b1);
        exp_q.push_back(line_of(w, 0));
        exp_q.push_back(line_of(w, 1));
        tick();  // handshake edge T
        in_valid = hold_next;
        in_data  = next_w;
        check_b("busy_after_hs", busy, 1'b1);
        check_b("ready_low_busy", in_ready, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            check_w("hold_line1", line1, cur1);
            check_w("hold_line2", line2, cur2);
            check_b("hold_done", done, 1'b0);
        end
        tick();  // commit edge T+33
        cur1 = exp_q.pop_front();
        cur2 = exp_q.pop_front();
        check_w("commit_line1", line1, cur1);
        check_w("commit_line2", line2, cur2);
        check_b("commit_done", done, 1'b1);
        check_b("commit_ready", in_ready, 1'b1);
        check_b("commit_busy", busy, 1'b0);
        if (!hold_next) begin
            tick();
            check_b("done_drop", done, 1'b0);
            check_w("stable_line1", line1, cur1);
        end
    endtask

    logic [127:0] w;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        cur1 = PAD_LINE;
        cur2 = PAD_LINE;
        check_w("rst_line1", line1, PAD_LINE);
        check_w("rst_line2", line2, PAD_LINE);
        check_b("rst_ready", in_ready, 1'b1);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_done", done, 1'b0);

        // Directed ascending byte pattern.
        w        = 128'h00112233445566778899AABBCCDDEEFF;
        in_valid = 1'b1;
        in_data  = w;
        run_word(w, 1'b0, '0);

        // Second word held during busy, accepted right after the commit.
        w        = 128'h0123456789ABCDEFFEDCBA9876543210;
        in_valid = 1'b1;
        in_data  = w;
        run_word(w, 1'b1, 128'h0);
        run_word(128'h0, 1'b0, '0);
        check_w("zero_line1_ascii", line1, 128'h30303030303030303030303030303030);

        // Identical consecutive words still run the whole sequence.
        w        = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'b1;
        in_data  = w;
        run_word(w, 1'b1, w);
        run_word(w, 1'b0, '0);

        // Random words with random idle gaps.
        for (int r = 0; r < 6; r++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            repeat ($urandom_range(0, 3)) tick();
            in_valid = 1'b1;
            in_data  = w;
            run_word(w, 1'b0, '0);
        end

        // Reset in the middle of a conversion aborts the word.
        w        = {128{1'b1}};
        in_valid = 1'b1;
        in_data  = w;
        tick();  // T
        in_valid = 1'b0;
        check_b("abort_busy", busy, 1'b1);
        repeat (19) tick();  // T+19
        rst = 1'b1;
        tick();  // T+20
        rst = 1'b0;
        cur1 = PAD_LINE;
        cur2 = PAD_LINE;
        check_w("abort_line1", line1, PAD_LINE);
        check_w("abort_line2", line2, PAD_LINE);
        check_b("abort_ready", in_ready, 1'b1);
        check_b("abort_busy0", busy, 1'b0);
        check_b("abort_done", done, 1'b0);
        tick();  // T+21
        check_b("abort_ready_t21", in_ready, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();
            check_b("abort_no_done", done, 1'b0);
        end
        check_w("abort_final_line1", line1, PAD_LINE);
        check_w("abort_final_line2", line2, PAD_LINE);

        // Reset and handshake on the same edge: no capture.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_b("rst_hs_busy", busy, 1'b0);
        check_b("rst_hs_ready", in_ready, 1'b1);
        tick();
        check_b("rst_hs_busy2", busy, 1'b0);
        check_w("rst_hs_line1", line1, PAD_LINE);

        // Recovery word after the resets.
        w        = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'b1;
        in_data  = w;
        run_word(w, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
